// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad row scanner with two-flop column synchronizer.
// Drives one active-low row at a time and freezes on a row while a key is seen,
// presenting an active-high column vector for the downstream debouncer.
module keypad_scanner #(
   parameter int unsigned SCAN_DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] col_raw,
   output logic [3:0] rows,
   output logic [1:0] row_idx,
   output logic [3:0] columns,
   output logic       scan_hold,
   output logic       multi_key
);

   typedef enum logic {
      SCAN,
      HOLD
   } state_e;

   localparam logic [7:0] LAST = 8'(SCAN_DIV - 1);

   state_e     state_q, state_d;
   logic [3:0] sync1_q, sync2_q;
   logic [1:0] row_idx_q, row_idx_d;
   logic [7:0] div_cnt_q, div_cnt_d;
   logic [7:0] idle_cnt_q, idle_cnt_d;
   logic [3:0] col_sync;

   assign col_sync = ~sync2_q;

   // Two-flop synchronizer for the asynchronous, pulled-up column lines.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= col_raw;
         sync2_q <= sync1_q;
      end
   end

   // State, row index and counter registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= SCAN;
         row_idx_q  <= '0;
         div_cnt_q  <= '0;
         idle_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         row_idx_q  <= row_idx_d;
         div_cnt_q  <= div_cnt_d;
         idle_cnt_q <= idle_cnt_d;
      end
   end

   // Next-state logic: dwell on each row, freeze while a key is present,
   // leave HOLD only after a full window of consecutive idle samples.
   always_comb begin
      state_d    = state_q;
      row_idx_d  = row_idx_q;
      div_cnt_d  = div_cnt_q;
      idle_cnt_d = idle_cnt_q;
      unique case (state_q)
         SCAN: begin
            if (div_cnt_q == LAST) begin
               if (col_sync != '0) begin
                  state_d    = HOLD;
                  idle_cnt_d = '0;
               end else begin
                  row_idx_d = row_idx_q + 2'd1;
                  div_cnt_d = '0;
               end
            end else begin
               div_cnt_d = div_cnt_q + 8'd1;
            end
         end
         HOLD: begin
            if (col_sync != '0) begin
               idle_cnt_d = '0;
            end else if (idle_cnt_q == LAST) begin
               state_d   = SCAN;
               row_idx_d = row_idx_q + 2'd1;
               div_cnt_d = '0;
            end else begin
               idle_cnt_d = idle_cnt_q + 8'd1;
            end
         end
         default: state_d = SCAN;
      endcase
   end

   // Outputs derive from registers only; more than one bit set is detected
   // by clearing the lowest set bit and testing for a remainder.
   assign row_idx   = row_idx_q;
   assign rows      = ~(4'b0001 << row_idx_q);
   assign scan_hold = (state_q == HOLD);
   assign columns   = scan_hold ? col_sync : '0;
   assign multi_key = scan_hold && ((columns & (columns - 4'd1)) != '0);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: table-driven scoreboard bench for keypad_scanner, SCAN_DIV = 4.
module tb_keypad_scanner;

   logic       clk;
   logic       reset;
   logic [3:0] col_raw;
   logic [3:0] rows;
   logic [1:0] row_idx;
   logic [3:0] columns;
   logic       scan_hold;
   logic       multi_key;

   // bit r*4+c set = key (row r, column c) pressed
   logic [15:0] keys;

   localparam logic [15:0] K21   = 16'h0200;
   localparam logic [15:0] K1013 = 16'h0090;

   typedef struct {
      logic [15:0] keys;
      logic [3:0]  rows;
      logic [1:0]  idx;
      logic [3:0]  cols;
      logic        hold;
      logic        multi;
   } vec_t;

   vec_t vt[33];
   vec_t exp_q[$];
   int   vectors;
   int   miscompares;

   keypad_scanner #(.SCAN_DIV(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .col_raw  (col_raw),
      .rows     (rows),
      .row_idx  (row_idx),
      .columns  (columns),
      .scan_hold(scan_hold),
      .multi_key(multi_key)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad model: a pressed key pulls its column low only while its row is driven.
   always_comb begin
      col_raw = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[4'(r * 4 + c)] && !rows[2'(r)]) col_raw[2'(c)] = 1'b0;
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input logic [3:0] r, input logic [1:0] i, input logic [3:0] c,
                       input logic h, input logic m);
      vec_t e;
      e.keys  = keys;
      e.rows  = r;
      e.idx   = i;
      e.cols  = c;
      e.hold  = h;
      e.multi = m;
      exp_q.push_back(e);
   endtask

   task automatic check_pop(input string name);
      vec_t e;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL %s: scoreboard empty", name);
         return;
      end
      e = exp_q.pop_front();
      if (rows !== e.rows || row_idx !== e.idx || columns !== e.cols ||
          scan_hold !== e.hold || multi_key !== e.multi) begin
         miscompares++;
         $display("FAIL %s: got rows=%b idx=%0d cols=%b hold=%b multi=%b, exp rows=%b idx=%0d cols=%b hold=%b multi=%b",
                  name, rows, row_idx, columns, scan_hold, multi_key,
                  e.rows, e.idx, e.cols, e.hold, e.multi);
      end
   endtask

   task automatic check_int(input string name, input int got, input int expv);
      vectors++;
      if (got != expv) begin
         miscompares++;
         $display("FAIL %s: got %0d, exp %0d", name, got, expv);
      end
   endtask

   // Bounded wait for scan_hold to reach lvl; an expired bound is a miscompare.
   task automatic wait_hold(input logic lvl, input int maxc, input string name);
      int n;
      n = 0;
      while (scan_hold !== lvl && n < maxc) begin
         tick();
         n++;
      end
      vectors++;
      if (scan_hold !== lvl) begin
         miscompares++;
         $display("FAIL %s: scan_hold=%b after %0d cycles, exp %b", name, scan_hold, n, lvl);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] rp[4];
      int n;
      rp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      vectors = 0;
      miscompares = 0;

      // Cycle k after the last reset edge: idle scan, then key (2,1) pressed from k=20.
      for (int k = 1; k <= 33; k++) begin
         vt[k-1].keys  = (k >= 20) ? K21 : 16'h0000;
         vt[k-1].idx   = (k >= 28) ? 2'd2 : 2'((k / 4) % 4);
         vt[k-1].rows  = rp[vt[k-1].idx];
         vt[k-1].hold  = (k >= 28);
         vt[k-1].cols  = (k >= 28) ? 4'b0010 : 4'b0000;
         vt[k-1].multi = 1'b0;
      end

      keys  = '0;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      push(4'b1110, 2'd0, 4'b0000, 1'b0, 1'b0);
      check_pop("reset");
      reset = 1'b1;

      for (int i = 0; i < 33; i++) begin
         keys = vt[i].keys;
         push(vt[i].rows, vt[i].idx, vt[i].cols, vt[i].hold, vt[i].multi);
         tick();
         check_pop($sformatf("vec%0d", i + 1));
      end

      // Release: HOLD must persist through synchronizer latency plus the idle window.
      keys = '0;
      n = 0;
      do begin
         tick();
         n++;
      end while (scan_hold && n < 12);
      check_int("release_latency", n, 6);
      push(4'b0111, 2'd3, 4'b0000, 1'b0, 1'b0);
      check_pop("after_release");

      // Re-acquire (2,1), then bounce: 2 released cycles inside HOLD.
      keys = K21;
      wait_hold(1'b1, 20, "rehold_wait");
      push(4'b1011, 2'd2, 4'b0010, 1'b1, 1'b0);
      check_pop("rehold");
      keys = '0;
      push(4'b1011, 2'd2, 4'b0010, 1'b1, 1'b0);
      tick();
      check_pop("bounce_r0");
      push(4'b1011, 2'd2, 4'b0000, 1'b1, 1'b0);
      tick();
      check_pop("bounce_r1");
      keys = K21;
      for (int i = 0; i < 10; i++) begin
         push(4'b1011, 2'd2, (i == 0) ? 4'b0000 : 4'b0010, 1'b1, 1'b0);
         tick();
         check_pop($sformatf("bounce_p%0d", i));
      end

      // Release, then two keys on row 1.
      keys = '0;
      wait_hold(1'b0, 12, "release2_wait");
      push(4'b0111, 2'd3, 4'b0000, 1'b0, 1'b0);
      check_pop("release2");
      keys = K1013;
      wait_hold(1'b1, 20, "multi_wait");
      push(4'b1101, 2'd1, 4'b1001, 1'b1, 1'b1);
      check_pop("multi");

      // Reset mid-HOLD aborts on the same edge even with keys still down.
      reset = 1'b0;
      push(4'b1110, 2'd0, 4'b0000, 1'b0, 1'b0);
      tick();
      check_pop("reset_in_hold");
      reset = 1'b1;
      push(4'b1110, 2'd0, 4'b0000, 1'b0, 1'b0);
      tick();
      check_pop("post_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Row-scanning front end for the 4x4 hex keypad. It drives the keypad rows one at a time (active-low) and brings the asynchronous column lines into the clock domain through a two-flop synchronizer. When a key is seen it freezes on that row and presents a clean, active-high one-hot column vector plus the row index. It sits directly upstream of the debouncer, whose `sig_in` is fed from `columns`.

## Interface
- `SCAN_DIV`, default 4: clock cycles each row is driven during scanning (dwell). This is also the idle-release window in HOLD. Legal range is 3..255.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `col_raw`  in  4  raw keypad columns. Asynchronous, pulled up, active-low (0 = key closed on the driven row).
- `rows`  out  4  keypad row drive. Active-low, exactly one bit low at all times.
- `row_idx`  out  2  index of the driven row (0..3). `rows` equals ~(1 << row_idx).
- `columns`  out  4  synchronized, active-high column vector. Forced to 0 when `scan_hold` = 0.
- `scan_hold`  out  1  1 while scanning is frozen on a row with a key present.
- `multi_key`  out  1  1 when `scan_hold` = 1 and more than one bit of `columns` is set.

## Operation
- Synchronizer: `col_raw` passes through two flops. The synchronized value is `col_sync` = ~(second flop). On reset, both flops load 4'b1111, so `col_sync` = 0.
- Counters:
  - `div_cnt` runs 0..SCAN_DIV-1.
  - `idle_cnt` runs 0..SCAN_DIV-1.
  - Both are 8 bits wide and compared against SCAN_DIV-1.
- States: SCAN, HOLD.
- SCAN:
  - `div_cnt` increments each cycle.
  - When `div_cnt` = SCAN_DIV-1:
    - If `col_sync` != 0: go to HOLD. `row_idx` is unchanged, `idle_cnt` is cleared.
    - Else: `row_idx` increments, wrapping 3 -> 0, and `div_cnt` is cleared.
  - `col_sync` is not examined before the last dwell cycle. This lets the synchronizer settle after a row change.
- HOLD:
  - `rows` and `row_idx` are frozen.
  - If `col_sync` != 0, clear `idle_cnt`.
  - Else, if `idle_cnt` = SCAN_DIV-1: go to SCAN, advance `row_idx` (with wrap), clear `div_cnt`.
  - Else, increment `idle_cnt`.
  - Any nonzero sample restarts the release window. Release bounce therefore never ends HOLD early.
- Outputs:
  - `scan_hold` = (state == HOLD).
  - `columns` = `scan_hold` ? `col_sync` : 4'b0000.
  - `multi_key` = `scan_hold` && (popcount(`columns`) > 1).
  - All outputs are functions of registers only. No path runs combinationally from `col_raw`.
- Reset (`reset` = 0 at a clock edge) values:
  - state = SCAN, `row_idx` = 0, `rows` = 4'b1110.
  - `div_cnt` = 0, `idle_cnt` = 0.
  - `columns` = 0, `scan_hold` = 0, `multi_key` = 0.
  - Reset mid-HOLD or mid-dwell aborts immediately to these values. Reset has priority over all transitions.

## Timing
- Synchronizer latency: a `col_raw` change is reflected in `col_sync` 2 clock edges later.
- Row dwell is exactly SCAN_DIV cycles. A full idle scan period is 4*SCAN_DIV cycles.
- Detection:
  - The SCAN -> HOLD decision uses `col_sync` in the last dwell cycle.
  - `scan_hold`, `columns`, `multi_key` become valid on the following edge.
  - `row_idx` does not change on that edge.
- Release:
  - The first cycle with `col_sync` = 0 in HOLD starts the idle count.
  - HOLD exits after SCAN_DIV consecutive zero samples.
  - `scan_hold` drops and `rows` advances on the same edge.
  - Worst case from raw release to `scan_hold` = 0 is 2 + SCAN_DIV cycles.
- A key on a row other than the driven one is invisible. It is caught when its row is next driven, within 4*SCAN_DIV cycles.
- Key change while in HOLD (different column, same row): `columns` follows `col_sync` with 2-cycle latency, and HOLD persists.

## Test plan
The bench keypad model drives `col_raw` low on column c only while `rows`[r] = 0 for each pressed key (r,c). SCAN_DIV = 4 throughout.
1. Reset: `reset` = 0 for 2 cycles -> `rows` = 1110, `row_idx` = 0, `columns` = 0000, `scan_hold` = 0, `multi_key` = 0.
2. Idle scan, no keys, 20 cycles -> `rows` steps 1110, 1101, 1011, 0111, 1110, 4 cycles each. `scan_hold` stays 0 and `columns` stays 0000.
3. Press (2,1) -> during row-2 dwell, `scan_hold` = 1, `row_idx` = 2, `rows` = 1011, `columns` = 0010, `multi_key` = 0. `rows` stays frozen while pressed.
4. Release (2,1) -> `scan_hold` = 0 exactly 6 cycles after `col_raw` returns to 1111, `rows` = 0111, `row_idx` = 3.
5. Bounce in HOLD: release for 2 cycles, re-press, hold 10 cycles -> `scan_hold` stays 1 throughout and `columns` returns to 0010.
6. Press (1,0) and (1,3) together -> `columns` = 1001, `multi_key` = 1. Then assert `reset` = 0 for one cycle mid-HOLD -> all outputs take reset values on that edge.
